// File: rtl/isl_de_gen.sv
// isl_de_gen: digitizer pixel pipeline that derives pixel/line counters from
// the input syncs and generates DE over a programmable active window.
// Two-stage pipeline: stage 1 = registered inputs + counters, stage 2 = outputs.
// Optional line/frame length measurement and line-lock detection are compiled
// in only when the macro ISL_DE_MEAS_EN is defined; otherwise htotal_o,
// vtotal_o and h_locked_o are tied to 0.

module isl_de_lane #(
  parameter int VEC_W = 8
) (
  input  logic             ISL_PCLK_i,
  input  logic             sys_reset_n,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] dout
);

  logic [VEC_W-1:0] s1;

  // two-stage colour delay, aligned with the counter/DE pipeline
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      s1   <= '0;
      dout <= '0;
    end else begin
      s1   <= din;
      dout <= s1;
    end
  end

endmodule

module isl_de_gen (
  input  logic        ISL_PCLK_i,
  input  logic        sys_reset_n,
  input  logic [7:0]  R_i,
  input  logic [7:0]  G_i,
  input  logic [7:0]  B_i,
  input  logic        HS_i,
  input  logic        VS_i,
  input  logic        hsync_pol,
  input  logic        vsync_pol,
  input  logic [8:0]  h_start,
  input  logic [10:0] h_active,
  input  logic [7:0]  v_start,
  input  logic [10:0] v_active,
  output logic [7:0]  R_o,
  output logic [7:0]  G_o,
  output logic [7:0]  B_o,
  output logic        HS_o,
  output logic        VS_o,
  output logic        DE_o,
  output logic [11:0] hcnt_o,
  output logic [10:0] vcnt_o,
  output logic [11:0] htotal_o,
  output logic [10:0] vtotal_o,
  output logic        h_locked_o
);

  localparam int          NUM_LANES = 3;
  localparam int          VEC_W     = 8;
  localparam logic [11:0] HCNT_MAX  = 12'hFFF;
  localparam logic [10:0] VCNT_MAX  = 11'h7FF;

  // ---------------------------------------------------------------- colour
  logic [NUM_LANES-1:0][VEC_W-1:0] pix_in;
  logic [NUM_LANES-1:0][VEC_W-1:0] pix_out;

  assign pix_in = {R_i, G_i, B_i};

  for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
    isl_de_lane #(.VEC_W(VEC_W)) u_lane (
      .ISL_PCLK_i (ISL_PCLK_i),
      .sys_reset_n(sys_reset_n),
      .din        (pix_in[gl]),
      .dout       (pix_out[gl])
    );
  end

  assign {R_o, G_o, B_o} = pix_out;

  // ---------------------------------------------------------------- syncs
  // Raw sync levels are kept in stage 1 so the outputs keep input polarity;
  // the active-high view is derived combinationally from the polarity inputs.
  logic s1_hs;
  logic s1_vs;
  logic hs_act_in;
  logic vs_act_in;
  logic hs_act_s1;
  logic vs_act_s1;
  logic hs_lead;
  logic vs_lead;

  assign hs_act_in = hsync_pol ? HS_i  : ~HS_i;
  assign vs_act_in = vsync_pol ? VS_i  : ~VS_i;
  assign hs_act_s1 = hsync_pol ? s1_hs : ~s1_hs;
  assign vs_act_s1 = vsync_pol ? s1_vs : ~s1_vs;

  // Leading edge lands on the sample entering stage 1 this clock, so the
  // counters below update in lockstep with the stage-1 pixel.
  assign hs_lead = hs_act_in & ~hs_act_s1;
  assign vs_lead = vs_act_in & ~vs_act_s1;

  // ---------------------------------------------------------------- counters
  logic [11:0] hcnt;
  logic [10:0] vcnt;
  logic        vs_pending;
  logic        h_run;
  logic        v_zero;

  // A VS edge in the same cycle as the HS edge zeroes that very line.
  assign v_zero = hs_lead & (vs_pending | vs_lead);

  // stage-1 sync capture plus pixel/line counters; both hold at 0 after
  // reset until the first HS leading edge starts counting
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      hcnt       <= '0;
      vcnt       <= '0;
      vs_pending <= 1'b0;
      h_run      <= 1'b0;
    end else begin
      s1_hs <= HS_i;
      s1_vs <= VS_i;
      if (hs_lead) begin
        h_run      <= 1'b1;
        hcnt       <= '0;
        vs_pending <= 1'b0;
        if (v_zero || !h_run)
          vcnt <= '0;
        else if (vcnt != VCNT_MAX)
          vcnt <= vcnt + 11'd1;
      end else begin
        if (vs_lead)
          vs_pending <= 1'b1;
        if (h_run && (hcnt != HCNT_MAX))
          hcnt <= hcnt + 12'd1;
      end
    end
  end

  // ---------------------------------------------------------------- DE
  // Window ends are 12 bits wide so start+active can never wrap; an active
  // length of 0 gives an empty window.
  logic [11:0] h_end;
  logic [11:0] v_end;
  logic [11:0] vcnt_w;
  logic        de_s1;

  assign h_end  = {3'b000, h_start} + {1'b0, h_active};
  assign v_end  = {4'b0000, v_start} + {1'b0, v_active};
  assign vcnt_w = {1'b0, vcnt};
  assign de_s1  = (hcnt >= {3'b000, h_start}) && (hcnt < h_end) &&
                  (vcnt_w >= {4'b0000, v_start}) && (vcnt_w < v_end);

  // stage-2 output register: syncs, DE and counters aligned to R_o/G_o/B_o
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      HS_o   <= 1'b0;
      VS_o   <= 1'b0;
      DE_o   <= 1'b0;
      hcnt_o <= '0;
      vcnt_o <= '0;
    end else begin
      HS_o   <= s1_hs;
      VS_o   <= s1_vs;
      DE_o   <= de_s1;
      hcnt_o <= hcnt;
      vcnt_o <= vcnt;
    end
  end

  // ---------------------------------------------------------------- measure
`ifdef ISL_DE_MEAS_EN
  logic [2:0]  lock_cnt;
  logic [2:0]  lock_nxt;
  logic        v_seen;
  logic [11:0] h_len;
  logic [10:0] v_len;

  // Completed length is last index + 1, clamped so a saturated counter
  // reports full scale instead of wrapping to 0.
  assign h_len = (hcnt == HCNT_MAX) ? HCNT_MAX : hcnt + 12'd1;
  assign v_len = (vcnt == VCNT_MAX) ? VCNT_MAX : vcnt + 11'd1;

  // consecutive-equal-line counter: restarts at 1 on a new value, caps at 4
  always_comb begin
    lock_nxt = lock_cnt;
    if (h_len != htotal_o)
      lock_nxt = 3'd1;
    else if (lock_cnt != 3'd4)
      lock_nxt = lock_cnt + 3'd1;
  end

  // line/frame length capture at HS edges; the partial line/frame seen
  // right after reset is never reported
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      htotal_o   <= '0;
      vtotal_o   <= '0;
      h_locked_o <= 1'b0;
      lock_cnt   <= '0;
      v_seen     <= 1'b0;
    end else if (hs_lead) begin
      if (h_run) begin
        htotal_o   <= h_len;
        lock_cnt   <= lock_nxt;
        h_locked_o <= (lock_nxt == 3'd4);
      end
      if (v_zero) begin
        v_seen <= 1'b1;
        if (v_seen)
          vtotal_o <= v_len;
      end
    end
  end
`else
  assign htotal_o   = '0;
  assign vtotal_o   = '0;
  assign h_locked_o = 1'b0;
`endif

endmodule

// File: tb/tb_isl_de_gen.sv
// Directed bench for isl_de_gen. Expected values come from the stimulus
// position (pixel index / line index) and hand-derived constants.
// Builds with or without ISL_DE_MEAS_EN; measurement expectations follow.

module tb_isl_de_gen;

  logic        ISL_PCLK_i = 1'b0;
  logic        sys_reset_n;
  logic [7:0]  R_i, G_i, B_i;
  logic        HS_i, VS_i;
  logic        hsync_pol, vsync_pol;
  logic [8:0]  h_start;
  logic [10:0] h_active;
  logic [7:0]  v_start;
  logic [10:0] v_active;
  logic [7:0]  R_o, G_o, B_o;
  logic        HS_o, VS_o, DE_o;
  logic [11:0] hcnt_o;
  logic [10:0] vcnt_o;
  logic [11:0] htotal_o;
  logic [10:0] vtotal_o;
  logic        h_locked_o;

  int total = 0;
  int bad   = 0;

`ifdef ISL_DE_MEAS_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  isl_de_gen dut (
    .ISL_PCLK_i(ISL_PCLK_i), .sys_reset_n(sys_reset_n),
    .R_i(R_i), .G_i(G_i), .B_i(B_i), .HS_i(HS_i), .VS_i(VS_i),
    .hsync_pol(hsync_pol), .vsync_pol(vsync_pol),
    .h_start(h_start), .h_active(h_active), .v_start(v_start), .v_active(v_active),
    .R_o(R_o), .G_o(G_o), .B_o(B_o), .HS_o(HS_o), .VS_o(VS_o), .DE_o(DE_o),
    .hcnt_o(hcnt_o), .vcnt_o(vcnt_o), .htotal_o(htotal_o), .vtotal_o(vtotal_o),
    .h_locked_o(h_locked_o)
  );

  always #5 ISL_PCLK_i = ~ISL_PCLK_i;

  // drive one pixel, then step past the next rising edge; on return the
  // outputs show the pixel driven by the previous call
  task automatic cyc(input logic hs, input logic vs, input logic [7:0] r,
                     input logic [7:0] g, input logic [7:0] b);
    HS_i = hs; VS_i = vs; R_i = r; G_i = g; B_i = b;
    @(posedge ISL_PCLK_i);
    #1;
  endtask

  task automatic do_reset(input logic hs_idle, input logic vs_idle);
    HS_i = hs_idle; VS_i = vs_idle; R_i = '0; G_i = '0; B_i = '0;
    sys_reset_n = 1'b0;
    repeat (3) @(posedge ISL_PCLK_i);
    #1 sys_reset_n = 1'b1;
    cyc(hs_idle, vs_idle, 8'd0, 8'd0, 8'd0);
    cyc(hs_idle, vs_idle, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic test_reset();
    hsync_pol = 1'b0; vsync_pol = 1'b0;
    h_start = 9'd122; h_active = 11'd720; v_start = 8'd0; v_active = 11'd100;
    R_i = 8'hA5; G_i = 8'h5A; B_i = 8'h3C; HS_i = 1'b1; VS_i = 1'b1;
    sys_reset_n = 1'b0;
    repeat (3) @(posedge ISL_PCLK_i);
    #1;
    total++; if ({R_o, G_o, B_o} !== 24'h0) begin bad++; $display("FAIL rst_rgb: got %h want 0", {R_o, G_o, B_o}); end
    total++; if ({HS_o, VS_o, DE_o} !== 3'b000) begin bad++; $display("FAIL rst_sync: got %b want 000", {HS_o, VS_o, DE_o}); end
    total++; if (hcnt_o !== 12'd0 || vcnt_o !== 11'd0) begin bad++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", hcnt_o, vcnt_o); end
    total++; if (htotal_o !== 12'd0 || vtotal_o !== 11'd0 || h_locked_o !== 1'b0) begin bad++; $display("FAIL rst_meas: got %0d/%0d/%b want 0/0/0", htotal_o, vtotal_o, h_locked_o); end
    #1 sys_reset_n = 1'b1;
    repeat (3) cyc(1'b1, 1'b1, 8'hA5, 8'h5A, 8'h3C);
    total++; if ({R_o, G_o, B_o} !== 24'hA55A3C) begin bad++; $display("FAIL rel_rgb: got %h want a55a3c", {R_o, G_o, B_o}); end
    total++; if ({HS_o, VS_o} !== 2'b11) begin bad++; $display("FAIL rel_pol: got %b want 11", {HS_o, VS_o}); end
    total++; if (hcnt_o !== 12'd0) begin bad++; $display("FAIL rel_hold: got %0d want 0", hcnt_o); end
    total++; if (DE_o !== 1'b0) begin bad++; $display("FAIL rel_de: got %b want 0", DE_o); end
  endtask

  // 858-pixel lines, 62-cycle active-low HS, active pixels 122..841
  task automatic test_h_timing();
    logic [11:0] ph;
    logic        pde;
    logic [7:0]  pr;
    logic        pv;
    int          decnt;
    hsync_pol = 1'b0; vsync_pol = 1'b0;
    h_start = 9'd122; h_active = 11'd720; v_start = 8'd0; v_active = 11'd2047;
    do_reset(1'b1, 1'b1);
    pv = 1'b0; decnt = 0; ph = '0; pde = 1'b0; pr = '0;
    for (int l = 0; l < 4; l++) begin
      for (int x = 0; x < 858; x++) begin
        cyc((x < 62) ? 1'b0 : 1'b1, 1'b1, 8'(x), 8'(l), 8'(x >> 8));
        if (pv) begin
          if (DE_o === 1'b1) decnt++;
          total++; if (DE_o !== pde) begin bad++; $display("FAIL h_de l=%0d x=%0d: got %b want %b", l, x, DE_o, pde); end
          total++; if (hcnt_o !== ph) begin bad++; $display("FAIL h_cnt l=%0d x=%0d: got %0d want %0d", l, x, hcnt_o, ph); end
          total++; if (R_o !== pr) begin bad++; $display("FAIL h_pix l=%0d x=%0d: got %0d want %0d", l, x, R_o, pr); end
        end
        pv  = 1'b1;
        ph  = 12'(x);
        pde = (x >= 122) && (x < 842);
        pr  = 8'(x);
      end
    end
    cyc(1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
    total++; if (DE_o !== pde) begin bad++; $display("FAIL h_de_last: got %b want %b", DE_o, pde); end
    total++; if (decnt != 4 * 720) begin bad++; $display("FAIL h_de_count: got %0d want %0d", decnt, 4 * 720); end
    total++; if (htotal_o !== (MEAS ? 12'd858 : 12'd0)) begin bad++; $display("FAIL h_total: got %0d want %0d", htotal_o, MEAS ? 858 : 0); end
    total++; if (h_locked_o !== 1'b0) begin bad++; $display("FAIL h_lock3: got %b want 0", h_locked_o); end
  endtask

  // five 858 lines then one 864; checked just after each line start
  task automatic test_lock();
    int lens [7];
    int eht  [7];
    bit elk  [7];
    lens = '{858, 858, 858, 858, 858, 864, 10};
    eht  = '{0, 858, 858, 858, 858, 858, 864};
    elk  = '{0, 0, 0, 0, 1, 1, 0};
    hsync_pol = 1'b0; vsync_pol = 1'b0;
    h_start = 9'd122; h_active = 11'd720; v_start = 8'd0; v_active = 11'd2047;
    do_reset(1'b1, 1'b1);
    for (int l = 0; l < 7; l++) begin
      for (int x = 0; x < lens[l]; x++) begin
        cyc((x < 62) ? 1'b0 : 1'b1, 1'b1, 8'(x), 8'(l), 8'd0);
        if (x == 1) begin
          total++; if (htotal_o !== 12'(MEAS ? eht[l] : 0)) begin bad++; $display("FAIL lock_ht l=%0d: got %0d want %0d", l, htotal_o, MEAS ? eht[l] : 0); end
          total++; if (h_locked_o !== (MEAS ? elk[l] : 1'b0)) begin bad++; $display("FAIL lock_lk l=%0d: got %b want %b", l, h_locked_o, MEAS ? elk[l] : 1'b0); end
        end
      end
    end
  endtask

  // 525-line frames of 20-pixel lines, VS edge coincident with line-0 HS edge
  task automatic test_frame();
    int nl;
    int evt;
    hsync_pol = 1'b0; vsync_pol = 1'b0;
    h_start = 9'd2; h_active = 11'd10; v_start = 8'd36; v_active = 11'd480;
    do_reset(1'b1, 1'b1);
    for (int f = 0; f < 3; f++) begin
      nl = (f == 2) ? 2 : 525;
      for (int l = 0; l < nl; l++) begin
        for (int x = 0; x < 20; x++) begin
          cyc((x < 4) ? 1'b0 : 1'b1, (l < 3) ? 1'b0 : 1'b1, 8'(x), 8'(l), 8'(f));
          if (x == 6) begin
            total++; if (vcnt_o !== 11'(l)) begin bad++; $display("FAIL f_vcnt f=%0d l=%0d: got %0d want %0d", f, l, vcnt_o, l); end
            total++; if (DE_o !== ((l >= 36) && (l < 516))) begin bad++; $display("FAIL f_de f=%0d l=%0d: got %b want %b", f, l, DE_o, (l >= 36) && (l < 516)); end
          end
          if (x == 6 && l == 1) begin
            evt = (f == 0) ? 0 : (MEAS ? 525 : 0);
            total++; if (vtotal_o !== 11'(evt)) begin bad++; $display("FAIL f_vtot f=%0d: got %0d want %0d", f, vtotal_o, evt); end
          end
          if (f == 0 && l == 40 && x == 2) begin
            total++; if (DE_o !== 1'b0) begin bad++; $display("FAIL f_hb1: got %b want 0", DE_o); end
          end
          if (f == 0 && l == 40 && x == 3) begin
            total++; if (DE_o !== 1'b1) begin bad++; $display("FAIL f_hb2: got %b want 1", DE_o); end
          end
          if (f == 0 && l == 40 && x == 12) begin
            total++; if (DE_o !== 1'b1) begin bad++; $display("FAIL f_hb11: got %b want 1", DE_o); end
          end
          if (f == 0 && l == 40 && x == 13) begin
            total++; if (DE_o !== 1'b0) begin bad++; $display("FAIL f_hb12: got %b want 0", DE_o); end
          end
        end
      end
    end
  endtask

  // active-high syncs; VS edge mid-line takes effect at the next HS edge
  task automatic test_vs_pending();
    int ev [7];
    logic vs;
    ev = '{0, 1, 2, 3, 4, 0, 1};
    hsync_pol = 1'b1; vsync_pol = 1'b1;
    h_start = 9'd0; h_active = 11'd10; v_start = 8'd0; v_active = 11'd100;
    do_reset(1'b0, 1'b0);
    for (int l = 0; l < 7; l++) begin
      for (int x = 0; x < 20; x++) begin
        vs = ((l == 4) && (x >= 10)) || (l == 5);
        cyc((x < 4) ? 1'b1 : 1'b0, vs, 8'(x), 8'(l), 8'd0);
        if (x == 15) begin
          total++; if (vcnt_o !== 11'(ev[l])) begin bad++; $display("FAIL vp_vcnt l=%0d: got %0d want %0d", l, vcnt_o, ev[l]); end
        end
        if (l == 2 && x == 2) begin
          total++; if (HS_o !== 1'b1) begin bad++; $display("FAIL vp_hs_act: got %b want 1", HS_o); end
        end
        if (l == 2 && x == 10) begin
          total++; if (HS_o !== 1'b0) begin bad++; $display("FAIL vp_hs_idle: got %b want 0", HS_o); end
        end
        if (l == 5 && x == 2) begin
          total++; if (VS_o !== 1'b1) begin bad++; $display("FAIL vp_vs_act: got %b want 1", VS_o); end
        end
      end
    end
  endtask

  // HS missing for 5000 cycles: hcnt pins at 4095 and DE window is left
  task automatic test_saturate();
    hsync_pol = 1'b1; vsync_pol = 1'b1;
    h_start = 9'd0; h_active = 11'd2047; v_start = 8'd0; v_active = 11'd2047;
    repeat (4) cyc(1'b1, 1'b0, 8'd1, 8'd2, 8'd3);
    for (int i = 0; i < 5000; i++) begin
      cyc(1'b0, 1'b0, 8'd1, 8'd2, 8'd3);
      if (i == 100) begin
        total++; if (DE_o !== 1'b1) begin bad++; $display("FAIL sat_de_mid: got %b want 1", DE_o); end
      end
    end
    total++; if (hcnt_o !== 12'd4095) begin bad++; $display("FAIL sat_hcnt: got %0d want 4095", hcnt_o); end
    total++; if (DE_o !== 1'b0) begin bad++; $display("FAIL sat_de: got %b want 0", DE_o); end
    cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    total++; if (hcnt_o !== 12'd4095) begin bad++; $display("FAIL sat_hold: got %0d want 4095", hcnt_o); end
    cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    total++; if (hcnt_o !== 12'd0) begin bad++; $display("FAIL sat_restart: got %0d want 0", hcnt_o); end
    total++; if (DE_o !== 1'b1) begin bad++; $display("FAIL sat_restart_de: got %b want 1", DE_o); end
  endtask

  // asynchronous reset mid-line, then counting waits for the next HS edge
  task automatic test_reset_midline();
    hsync_pol = 1'b0; vsync_pol = 1'b0;
    h_start = 9'd122; h_active = 11'd720; v_start = 8'd0; v_active = 11'd2047;
    do_reset(1'b1, 1'b1);
    for (int x = 0; x <= 300; x++) cyc((x < 62) ? 1'b0 : 1'b1, 1'b1, 8'(x), 8'd7, 8'd9);
    total++; if (DE_o !== 1'b1 || hcnt_o !== 12'd299) begin bad++; $display("FAIL mr_pre: got %b/%0d want 1/299", DE_o, hcnt_o); end
    #2 sys_reset_n = 1'b0;
    #1;
    total++; if (DE_o !== 1'b0 || hcnt_o !== 12'd0) begin bad++; $display("FAIL mr_async: got %b/%0d want 0/0", DE_o, hcnt_o); end
    total++; if ({R_o, G_o, B_o, HS_o, VS_o} !== 26'd0) begin bad++; $display("FAIL mr_async_pix: got %h want 0", {R_o, G_o, B_o, HS_o, VS_o}); end
    repeat (2) @(posedge ISL_PCLK_i);
    #1 sys_reset_n = 1'b1;
    repeat (5) cyc(1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
    total++; if (hcnt_o !== 12'd0) begin bad++; $display("FAIL mr_idle: got %0d want 0", hcnt_o); end
    for (int x = 0; x < 126; x++) begin
      cyc((x < 62) ? 1'b0 : 1'b1, 1'b1, 8'(x), 8'd0, 8'd0);
      if (x == 122) begin
        total++; if (DE_o !== 1'b0) begin bad++; $display("FAIL mr_de121: got %b want 0", DE_o); end
      end
      if (x == 123) begin
        total++; if (DE_o !== 1'b1) begin bad++; $display("FAIL mr_de122: got %b want 1", DE_o); end
      end
      if (x == 125) begin
        total++; if (hcnt_o !== 12'd124) begin bad++; $display("FAIL mr_hcnt: got %0d want 124", hcnt_o); end
      end
    end
  endtask

  // zero active length in either axis keeps DE low; nonzero control after
  task automatic test_zero_active();
    int decnt;
    hsync_pol = 1'b0; vsync_pol = 1'b0;
    h_start = 9'd0; h_active = 11'd0; v_start = 8'd0; v_active = 11'd100;
    do_reset(1'b1, 1'b1);
    decnt = 0;
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < 100; x++) begin
        cyc((x < 4) ? 1'b0 : 1'b1, 1'b1, 8'(x), 8'd0, 8'd0);
        if (DE_o === 1'b1) decnt++;
      end
    total++; if (decnt != 0) begin bad++; $display("FAIL za_h0: got %0d want 0", decnt); end
    h_active = 11'd50; v_active = 11'd0;
    decnt = 0;
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < 100; x++) begin
        cyc((x < 4) ? 1'b0 : 1'b1, 1'b1, 8'(x), 8'd0, 8'd0);
        if (DE_o === 1'b1) decnt++;
      end
    total++; if (decnt != 0) begin bad++; $display("FAIL za_v0: got %0d want 0", decnt); end
    v_active = 11'd100;
    decnt = 0;
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < 100; x++) begin
        cyc((x < 4) ? 1'b0 : 1'b1, 1'b1, 8'(x), 8'd0, 8'd0);
        if (DE_o === 1'b1) decnt++;
      end
    total++; if (decnt != 100) begin bad++; $display("FAIL za_ctrl: got %0d want 100", decnt); end
  endtask

  initial begin
    sys_reset_n = 1'b0;
    R_i = '0; G_i = '0; B_i = '0; HS_i = 1'b1; VS_i = 1'b1;
    hsync_pol = 1'b0; vsync_pol = 1'b0;
    h_start = '0; h_active = '0; v_start = '0; v_active = '0;
    test_reset();
    test_h_timing();
    test_lock();
    test_frame();
    test_vs_pending();
    test_saturate();
    test_reset_midline();
    test_zero_active();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/isl_de_gen.md
ISL_DE_GEN -- requirements
Module: isl_de_gen

Interface
REQ-001 SHALL have ports: ISL_PCLK_i  in  1  capture pixel clock; all logic on its rising edge.
REQ-002 SHALL have ports: sys_reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: R_i/G_i/B_i  in  8 each  digitizer pixel data.
REQ-004 SHALL have ports: HS_i, VS_i  in  1 each  horizontal sync and pclk-synchronized vertical sync.
REQ-005 SHALL have ports: hsync_pol, vsync_pol  in  1 each  1 = active-high input sync, 0 = active-low.
REQ-006 SHALL have ports: h_start  in  9  pixels from HS leading edge to first active pixel; h_active  in  11  active pixels per line.
REQ-007 SHALL have ports: v_start  in  8  lines from VS line to first active line; v_active  in  11  active lines.
REQ-008 SHALL have ports: R_o/G_o/B_o  out  8 each; HS_o, VS_o  out  1 each, input polarity preserved; DE_o  out  1.
REQ-009 SHALL have ports: hcnt_o  out  12  pixel index in line; vcnt_o  out  11  line index in frame.
REQ-010 SHALL have ports: htotal_o  out  12  measured line length; vtotal_o  out  11  measured frame length; h_locked_o  out  1  line length stable.

Function
REQ-011 SHALL register all data and sync inputs into stage 1; outputs SHALL be a stage-2 register, giving 2-cycle latency input to output with DE_o aligned to its pixel.
REQ-012 SHALL normalize syncs: hs_act = hsync_pol ? HS : ~HS; vs_act likewise; leading edge = rising edge of hs_act/vs_act between consecutive stage-1 samples.
REQ-013 hcnt SHALL load 0 on the stage-1 cycle holding the HS leading edge, else increment, saturating at 4095.
REQ-014 A VS leading edge SHALL set vs_pending; at the next HS leading edge vcnt SHALL load 0 and clear vs_pending, else vcnt increments, saturating at 2047.
REQ-015 VS and HS leading edges in the same cycle SHALL zero vcnt on that same line.
REQ-016 DE_o SHALL be 1 iff h_start <= hcnt < h_start+h_active and v_start <= vcnt < v_start+v_active; sums computed 12 bits wide, no wrap.
REQ-017 h_active = 0 or v_active = 0 SHALL hold DE_o at 0.
REQ-018 hcnt_o/vcnt_o SHALL be the stage-1 counters registered alongside the pixel, i.e. aligned with R_o/G_o/B_o.
REQ-019 A saturated hcnt SHALL not wrap; DE_o follows REQ-016 using the saturated value.

Reset
REQ-020 On sys_reset_n low, all outputs, counters, vs_pending, stage registers and lock counter SHALL clear to 0 immediately.
REQ-021 After release, the first HS leading edge SHALL start normal counting; vtotal_o stays 0 until two VS lines are seen.

Configuration
REQ-022 With macro ISL_DE_MEAS_EN defined: measurement logic per REQ-023..REQ-025 is compiled in.
REQ-023 At each HS leading edge, htotal_o SHALL load hcnt+1 of the completed line; the first edge after reset SHALL not load.
REQ-024 h_locked_o SHALL assert after 4 consecutive equal htotal values and deassert in the cycle a differing value loads; lock counter saturates at 4.
REQ-025 At the HS edge zeroing vcnt, vtotal_o SHALL load vcnt+1 of the completed frame.
REQ-026 Without ISL_DE_MEAS_EN: htotal_o, vtotal_o, h_locked_o SHALL be constant 0, no measurement registers; REQ-011..REQ-019 unchanged.

Verification
REQ-027 858-pixel lines, 62-cycle active-low HS, hsync_pol=0, h_start=122, h_active=720 -> DE_o high 720 cycles per line for hcnt 122..841, 2 cycles after matching input pixel.
REQ-028 525-line frames, VS on line 0, v_start=36, v_active=480 -> DE_o lines vcnt 36..515; vtotal_o=525 (MEAS_EN).
REQ-029 Five 858-pixel lines then one 864 -> h_locked_o=1 after 4th equal line, drops on the 864 load, htotal_o=864.
REQ-030 HS and VS leading edges in the same cycle -> vcnt_o=0 for that line; HS absent 5000 cycles -> hcnt_o holds 4095.
REQ-031 sys_reset_n pulsed low mid-line -> all outputs 0 asynchronously; counting resumes at the next HS edge.
REQ-032 Build without ISL_DE_MEAS_EN -> REQ-027 DE timing identical; htotal_o/vtotal_o/h_locked_o stay 0.
